// File: rtl/cc_capture_fifo_if.sv
// Handshake bundle between the cc capture FIFO and its producer/consumer.
// The producer side also acts as the consumer, so one master modport covers both.
interface cc_capture_fifo_if;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_vec;
    logic        out_changed;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_vec, out_changed
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_vec, out_changed
    );
endinterface

// File: rtl/cc_capture_fifo.sv
// cc_capture_fifo: registers the 20-bit cc output vector into a small FIFO,
// tags each entry with a changed-since-previous flag, counts changes with a
// saturating counter and records sticky overflow (dropped) events.
module cc_capture_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    cc_capture_fifo_if.slave       bus,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       change_count,
    output logic                   dropped
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int VEC_W = 20;
    localparam logic [PTR_W:0]   LVL_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Each entry stores {changed, vector}.
    logic [VEC_W:0]   mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [VEC_W-1:0] prev;
    logic             prev_seen;
    logic             push;
    logic             pop;
    logic             changed;
    logic [VEC_W:0]   head;

    assign bus.in_ready  = (level != LVL_FULL);
    assign bus.out_valid = (level != '0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;
    assign changed       = prev_seen & (bus.in_vec != prev);

    // Head entry is masked while empty so outputs read zero after reset/clear.
    assign head            = mem[rd_ptr];
    assign bus.out_vec     = bus.out_valid ? head[VEC_W-1:0] : '0;
    assign bus.out_changed = bus.out_valid & head[VEC_W];

    // Entry storage: written on an accepted push; clear discards the vector.
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            mem[wr_ptr] <= {changed, bus.in_vec};
        end
    end

    // Occupancy and pointer control; simultaneous push and pop keep level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            level  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // History of the last accepted vector; dropped vectors never update it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev      <= '0;
            prev_seen <= 1'b0;
        end else if (clear) begin
            prev_seen <= 1'b0;
        end else if (push) begin
            prev      <= bus.in_vec;
            prev_seen <= 1'b1;
        end
    end

    // Change statistics and sticky overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            change_count <= '0;
            dropped      <= 1'b0;
        end else if (clear) begin
            change_count <= '0;
            dropped      <= 1'b0;
        end else begin
            if (push && changed) begin
                change_count <= sat_inc(change_count);
            end
            if (bus.in_valid && !bus.in_ready) begin
                dropped <= 1'b1;
            end
        end
    end
endmodule
